// File: rtl/fn_alu_pipe_if.sv
// rtl/fn_alu_pipe_if.sv - operand/result handshake bundle for fn_alu_pipe
interface fn_alu_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic             acc_mode;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             carry;
   logic             zero;
   logic [WIDTH-1:0] acc;

   modport master (
      output in_valid, a, b, sel, acc_mode, acc_clr, out_ready,
      input  in_ready, out_valid, y, carry, zero, acc
   );

   modport slave (
      input  in_valid, a, b, sel, acc_mode, acc_clr, out_ready,
      output in_ready, out_valid, y, carry, zero, acc
   );
endinterface

// File: rtl/fn_alu_pipe.sv
// rtl/fn_alu_pipe.sv - two-stage valid/ready ALU with optional accumulator
module fn_alu_pipe #(
   parameter int WIDTH  = 8,
   parameter int ACC_EN = 1
) (
   input logic          clk,
   input logic          rst,
   fn_alu_pipe_if.slave bus
);
   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_XNOR = 3'b011;
   localparam logic [2:0] OP_NAND = 3'b100;
   localparam logic [2:0] OP_NOR  = 3'b101;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b111;

   logic             r_s1_valid;
   logic [WIDTH-1:0] r_s1_a;
   logic [WIDTH-1:0] r_s1_b;
   logic [2:0]       r_s1_sel;
   logic             r_s1_acc_mode;

   logic             r_s2_valid;
   logic [WIDTH-1:0] r_y;
   logic             r_carry;
   logic             r_zero;
   logic [WIDTH-1:0] r_acc;

   logic             w_s2_load;
   logic             w_in_ready;
   logic             w_in_xfer;
   logic [WIDTH-1:0] w_op_b;
   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_res;
   logic             w_carry;

   assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready);
   assign w_in_ready = !r_s1_valid || w_s2_load;
   assign w_in_xfer  = bus.in_valid && w_in_ready;

   // Reading r_acc here (not a copy taken at S1) lets back-to-back acc items chain
   assign w_op_b = ((ACC_EN != 0) && r_s1_acc_mode) ? r_acc : r_s1_b;
   assign w_sum  = {1'b0, r_s1_a} + {1'b0, w_op_b};
   assign w_diff = {1'b0, r_s1_a} - {1'b0, w_op_b};

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      case (r_s1_sel)
         OP_AND:  w_res = r_s1_a & w_op_b;
         OP_OR:   w_res = r_s1_a | w_op_b;
         OP_XOR:  w_res = r_s1_a ^ w_op_b;
         OP_XNOR: w_res = ~(r_s1_a ^ w_op_b);
         OP_NAND: w_res = ~(r_s1_a & w_op_b);
         OP_NOR:  w_res = ~(r_s1_a | w_op_b);
         OP_ADD: begin
            w_res   = w_sum[WIDTH-1:0];
            w_carry = w_sum[WIDTH];
         end
         OP_SUB: begin
            w_res   = w_diff[WIDTH-1:0];
            w_carry = w_diff[WIDTH];
         end
         default: begin
            w_res   = '0;
            w_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_in_xfer) begin
         r_s1_valid    <= 1'b1;
         r_s1_a        <= bus.a;
         r_s1_b        <= bus.b;
         r_s1_sel      <= bus.sel;
         r_s1_acc_mode <= bus.acc_mode;
      end else if (w_s2_load) begin
         r_s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_y        <= '0;
         r_carry    <= 1'b0;
         r_zero     <= 1'b1;
      end else if (w_s2_load) begin
         r_s2_valid <= 1'b1;
         r_y        <= w_res;
         r_carry    <= w_carry;
         r_zero     <= (w_res == '0);
      end else if (bus.out_ready) begin
         r_s2_valid <= 1'b0;
      end
   end

   generate
      if (ACC_EN != 0) begin : g_acc
         always_ff @(posedge clk) begin
            if (rst || bus.acc_clr) begin
               r_acc <= '0;
            end else if (w_s2_load && r_s1_acc_mode) begin
               r_acc <= w_res;
            end
         end
      end else begin : g_no_acc
         assign r_acc = '0;
      end
   endgenerate

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_s2_valid;
   assign bus.y         = r_y;
   assign bus.carry     = r_carry;
   assign bus.zero      = r_zero;
   assign bus.acc       = r_acc;
endmodule

// File: tb/tb_fn_alu_pipe.sv
// tb/tb_fn_alu_pipe.sv - scoreboard bench for fn_alu_pipe at WIDTH=8
module tb_fn_alu_pipe;
   typedef struct {
      logic [7:0] y;
      logic       c;
      logic       z;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t q[$];

   fn_alu_pipe_if #(.WIDTH(8)) bus ();

   fn_alu_pipe #(.WIDTH(8), .ACC_EN(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      logic [8:0] t;
      logic [7:0] r;
      logic       c;
      c = 1'b0;
      case (s)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~(a ^ b);
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: begin t = a + b; r = t[7:0]; c = t[8]; end
         default: begin r = a - b; c = (a < b); end
      endcase
      return {r, c, (r == 8'h00)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] ey, input logic ec, input int ecyc);
      exp_t e;
      e.y = ey; e.c = ec; e.z = (ey == 8'h00); e.cyc = ecyc;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s, input logic am,
                       input logic [7:0] ey, input logic ec, input bit lat, input bit do_push);
      int w;
      bus.a = a; bus.b = b; bus.sel = s; bus.acc_mode = am;
      bus.in_valid = 1'b1;
      w = 0;
      while (!bus.in_ready && w < 50) begin
         step();
         w++;
      end
      chk("send_in_ready", bus.in_ready, 1);
      if (do_push) push(ey, ec, lat ? cyc + 2 : -1);
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (q.size() != 0 && w < 100) begin
         step();
         w++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (bus.out_valid && bus.out_ready) begin
         n_vec++;
         assert (q.size() != 0)
         else begin
            n_err++;
            $error("FAIL unexpected_out observed y=%0h expected no output", bus.y);
         end
         if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            assert ({bus.y, bus.carry, bus.zero} === {e.y, e.c, e.z})
            else begin
               n_err++;
               $error("FAIL result observed y=%0h c=%0b z=%0b expected y=%0h c=%0b z=%0b",
                      bus.y, bus.carry, bus.zero, e.y, e.c, e.z);
            end
            if (e.cyc >= 0) begin
               n_vec++;
               assert (cyc == e.cyc)
               else begin
                  n_err++;
                  $error("FAIL latency observed cycle=%0d expected cycle=%0d", cyc, e.cyc);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] sweep_y [8];
      logic [7:0] y_hold;
      logic [9:0] m;
      int         idx;
      sweep_y = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h8B};
      bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0;
      bus.acc_mode = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b1;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_y", bus.y, 0);
      chk("rst_carry", bus.carry, 0);
      chk("rst_zero", bus.zero, 1);
      chk("rst_acc", bus.acc, 0);

      for (int i = 0; i < 8; i++) send(8'hC5, 8'h3A, 3'(i), 1'b0, sweep_y[i], 1'b0, 1'b1, 1'b1);
      drain();

      send(8'hF0, 8'h20, 3'd6, 1'b0, 8'h10, 1'b1, 1'b1, 1'b1);
      send(8'h05, 8'h05, 3'd7, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      send(8'h01, 8'h02, 3'd7, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b1);
      drain();

      // stall window: out_ready low for stream cycles 3..6
      idx = 0;
      y_hold = '0;
      for (int k = 0; k < 20; k++) begin
         bus.out_ready = !(k >= 3 && k <= 6);
         if (idx < 6) begin
            bus.a = 8'(idx * 37 + 11); bus.b = 8'(idx * 53 + 7);
            bus.sel = 3'(idx + 2); bus.acc_mode = 1'b0; bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (k == 3) begin
            chk("stall_in_ready_low", bus.in_ready, 0);
            chk("stall_out_valid", bus.out_valid, 1);
            y_hold = bus.y;
         end
         if (k >= 4 && k <= 6) chk("stall_y_stable", bus.y, y_hold);
         if (idx < 6 && bus.in_ready) begin
            m = model(bus.a, bus.b, bus.sel);
            push(m[9:2], m[1], -1);
            idx++;
         end
         step();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      chk("stream_all_sent", idx, 6);
      drain();

      bus.acc_clr = 1'b1;
      step();
      bus.acc_clr = 1'b0;
      chk("acc_clr", bus.acc, 0);
      for (int i = 1; i <= 4; i++) send(8'h03, 8'hAA, 3'd6, 1'b1, 8'(3 * i), 1'b0, 1'b1, 1'b1);
      drain();
      chk("acc_chain", bus.acc, 12);
      send(8'h01, 8'h55, 3'd6, 1'b1, 8'd13, 1'b0, 1'b1, 1'b1);
      bus.acc_clr = 1'b1;
      step();
      bus.acc_clr = 1'b0;
      chk("acc_clr_wins", bus.acc, 0);
      drain();

      send(8'h05, 8'h00, 3'd6, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1);
      send(8'h04, 8'h05, 3'd6, 1'b0, 8'h09, 1'b0, 1'b1, 1'b1);
      drain();
      chk("acc_untouched", bus.acc, 5);

      bus.out_ready = 1'b0;
      send(8'h11, 8'h22, 3'd6, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      send(8'h33, 8'h44, 3'd6, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("pre_rst_full", bus.in_ready, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_in_ready", bus.in_ready, 1);
      chk("mid_rst_acc", bus.acc, 0);
      chk("mid_rst_zero", bus.zero, 1);
      for (int i = 0; i < 6; i++) step();
      chk("no_stale", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fn_alu_pipe.md
FN_ALU_PIPE -- requirements
Module: fn_alu_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal 1..32).
REQ-002 SHALL provide parameter ACC_EN, default 1, enable for accumulate mode; 0 removes acc logic and forces port acc to 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand transaction offered.
REQ-006 in_ready  output  1  block can accept a transaction this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 sel  input  3  operation select.
REQ-010 acc_mode  input  1  use accumulator in place of b and write result back to it.
REQ-011 acc_clr  input  1  synchronous clear of accumulator.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  downstream accepts result.
REQ-014 y  output  WIDTH  result.
REQ-015 carry  output  1  carry/borrow flag of result.
REQ-016 zero  output  1  y == 0.
REQ-017 acc  output  WIDTH  current accumulator value.

Function
REQ-018 sel decode SHALL be: 000 a&b, 001 a|b, 010 a^b, 011 ~(a^b), 100 ~(a&b), 101 ~(a|b), 110 a+b, 111 a-b (modulo 2^WIDTH).
REQ-019 carry SHALL be the carry-out bit for ADD, 1 when a<b unsigned for SUB, 0 for all logic ops.
REQ-020 Transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-021 Pipeline SHALL be two registered stages: S1 captures a, b, sel, acc_mode; S2 computes and registers y, carry, zero.
REQ-022 Latency SHALL be exactly 2 cycles from input transfer edge to out_valid high when out_ready held 1.
REQ-023 S2 SHALL load when S1 valid and (S2 empty or out_ready); in_ready = !S1_valid || S2 load condition.
REQ-024 Throughput SHALL be one transaction per cycle with out_ready held 1; no bubbles inserted.
REQ-025 With out_ready low, both stages SHALL fill, then in_ready SHALL drop; y/carry/zero SHALL hold stable while out_valid && !out_ready.
REQ-026 No transaction SHALL be lost or duplicated under any in_valid/out_ready pattern.
REQ-027 Accumulate: when S1 item has acc_mode=1, S2 SHALL use acc in place of b and, on the S2 load edge, acc SHALL take the result.
REQ-028 Back-to-back acc_mode items SHALL chain: each sees the acc written by its predecessor (no hazard).
REQ-029 acc_clr SHALL zero acc on the next edge; if coincident with an acc write-back, clear SHALL win.
REQ-030 acc_mode=0 items SHALL neither read nor modify acc.
REQ-031 Inputs a, b, sel, acc_mode SHALL be sampled only on input transfer; values otherwise are don't-care.

Reset
REQ-032 rst SHALL, on the clock edge, clear both stage valids, set out_valid=0, y=0, carry=0, zero=1, acc=0.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 rst asserted mid-stream SHALL discard all in-flight items; no out_valid pulse for them after reset.
REQ-035 rst SHALL take priority over any concurrent transfer or acc_clr.

Verification (WIDTH=8)
REQ-036 Sweep sel 0..7 with a=8'hC5, b=8'h3A, out_ready=1 -> y = 00, FF, FF, 00, FF, 00, FF(carry 0), 8B(carry 0), each 2 cycles after its transfer.
REQ-037 ADD a=8'hF0, b=8'h20 -> y=8'h10, carry=1; SUB a=8'h05, b=8'h05 -> y=0, zero=1, carry=0; SUB a=1,b=2 -> y=FF, carry=1.
REQ-038 Stream 6 items, out_ready low cycles 3-6 -> in_ready low after 2 held items, y stable while stalled, all 6 results in order, none duplicated.
REQ-039 acc_clr then ADD acc_mode a=3 four times back-to-back -> y=3,6,9,12; acc=12; then acc_clr coincident with a write-back -> acc=0.
REQ-040 rst for one cycle with 2 items in flight -> out_valid 0 next cycle, no stale results emerge, acc=0, in_ready=1.
